// File: rtl/burst_mem_responder_if.sv
// Request/response bundle between a memory initiator and burst_mem_responder.
// The initiator drives the request side; the responder drives busy, read data and err.
interface burst_mem_responder_if #(
   parameter int unsigned address_width = 32,
   parameter int unsigned data_width    = 32
);
   logic [address_width-1:0] address;
   logic [data_width-1:0]    data_in;
   logic [data_width-1:0]    data_out;
   logic [1:0]               access_size;
   logic                     rw;
   logic                     enable;
   logic                     busy;
   logic                     err;

   modport master (
      output address, data_in, access_size, rw, enable,
      input  busy, data_out, err
   );

   modport slave (
      input  address, data_in, access_size, rw, enable,
      output busy, data_out, err
   );
endinterface

// File: rtl/burst_mem_responder.sv
// Big-endian word memory mapped at base_addr, serving single-word and 4/8/16-beat
// read/write bursts; beat 0 executes on the accept edge, busy covers the rest.
module burst_mem_responder #(
   parameter int unsigned               data_width    = 32,
   parameter int unsigned               address_width = 32,
   parameter int unsigned               depth         = 1048576,
   parameter logic [address_width-1:0]  base_addr     = 32'h80020000
) (
   input logic                  clock,
   input logic                  reset,
   burst_mem_responder_if.slave bus
);
   localparam int unsigned words = depth / 4;
   localparam int unsigned idx_w = $clog2(words);

   typedef enum logic [1:0] {IDLE, RBURST, WBURST} state_t;

   state_t                   state;
   logic [3:0]               remaining;
   logic [address_width-1:0] cur_addr;
   logic [data_width-1:0]    mem [words];

   logic                     beat_go;
   logic                     beat_rd;
   logic [address_width-1:0] beat_addr;
   logic [address_width-1:0] beat_off;
   logic                     beat_ok;
   logic [idx_w-1:0]         beat_idx;
   logic [3:0]               burst_len_m1;
   logic                     mem_we;

   // Beat selection: the request itself in IDLE, the running burst otherwise.
   always_comb begin
      beat_go      = 1'b0;
      beat_rd      = 1'b0;
      beat_addr    = cur_addr;
      burst_len_m1 = 4'd0;
      case (bus.access_size)
         2'b00:   burst_len_m1 = 4'd0;
         2'b01:   burst_len_m1 = 4'd3;
         2'b10:   burst_len_m1 = 4'd7;
         default: burst_len_m1 = 4'd15;
      endcase
      unique case (state)
         IDLE: begin
            beat_go   = bus.enable;
            beat_rd   = bus.rw;
            beat_addr = bus.address & ~address_width'(3);
         end
         RBURST: begin
            beat_go = 1'b1;
            beat_rd = 1'b1;
         end
         WBURST: begin
            beat_go = 1'b1;
         end
         default: ;
      endcase
      // Unsigned offset from base makes addresses below base wrap high and fail.
      beat_off = beat_addr - base_addr;
      beat_ok  = beat_off <= address_width'(depth - 4);
      beat_idx = beat_off[idx_w+1:2];
      mem_we   = beat_go && !beat_rd && beat_ok;
   end

   // Words are held with the lowest byte address in [31:24], i.e. big-endian.
   always_ff @(posedge clock) begin
      if (mem_we && !reset) begin
         mem[beat_idx] <= bus.data_in;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         remaining    <= 4'd0;
         cur_addr     <= '0;
         bus.busy     <= 1'b0;
         bus.data_out <= '0;
         bus.err      <= 1'b0;
      end else begin
         bus.err <= beat_go && !beat_ok;
         if (beat_go) begin
            cur_addr <= beat_addr + address_width'(4);
         end
         if (beat_go && beat_rd) begin
            bus.data_out <= beat_ok ? mem[beat_idx] : '0;
         end
         unique case (state)
            IDLE: begin
               if (bus.enable && burst_len_m1 != 4'd0) begin
                  state     <= bus.rw ? RBURST : WBURST;
                  remaining <= burst_len_m1;
                  bus.busy  <= 1'b1;
               end
            end
            RBURST, WBURST: begin
               remaining <= remaining - 4'd1;
               if (remaining == 4'd1) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/burst_mem_responder.md
# burst_mem_responder

Responder end of the processor's memory access protocol: the block that serves reads and writes issued by the program loader, fetch and later load/store stages. It holds a big-endian, byte-addressed MIPS memory image mapped at `base_addr` and answers single-word and burst transfers selected by `access_size`. A `busy` handshake covers the burst beats. It is the synthesizable, burst-capable replacement for the behavioural memory model on the same port.

## Interface
- `data_width`, 32, data bus width in bits (fixed at 32)
- `address_width`, 32, byte address width
- `depth`, 1048576, memory size in bytes (multiple of 4)
- `base_addr`, 32'h80020000, byte address of memory location 0
- `clock`  in  1  single clock; all state changes on posedge
- `reset`  in  1  asynchronous, active-high reset
- `address`  in  32  byte address of first beat; bits [1:0] ignored
- `data_in`  in  32  write data, sampled once per write beat
- `access_size`  in  2  burst length: 00=1 word, 01=4, 10=8, 11=16
- `rw`  in  1  0=write, 1=read
- `enable`  in  1  request valid
- `busy`  out  1  high while a burst has beats remaining; requests ignored
- `data_out`  out  32  read data, registered
- `err`  out  1  one-cycle pulse per beat that falls outside the mapped range

## Operation
- States: IDLE, RBURST, WBURST.
- IDLE accept: on a posedge with `enable`=1 and `busy`=0, the block latches `rw`, the beat count N (1/4/8/16) and the word address `{address[31:2],2'b00}`. Beat 0 executes on this same edge.
- Read beat: `data_out` <= word at the current address, assembled big-endian (lowest byte address goes to [31:24]).
- Write beat: the `data_in` bytes are stored big-endian at the current address.
- Address advance: after each beat, address += 4, modulo 2^32.
- Burst states:
  - If N=1, the block stays in IDLE.
  - Otherwise it enters RBURST or WBURST with remaining = N-1.
  - Each following posedge executes one beat and decrements remaining.
  - When remaining reaches 0, the block returns to IDLE.
- While in a burst state, `enable`, `address`, `rw` and `access_size` are ignored. Write beats sample `data_in` every cycle.
- Range check: a beat is valid iff `base_addr` <= addr <= `base_addr`+`depth`-4, using unsigned compare on the 32-bit difference.
  - Invalid read: `data_out` <= 0.
  - Invalid write: dropped, memory unchanged.
  - In both cases `err`=1 for that cycle.
- A burst that crosses the top of the range continues with invalid beats; it does not truncate.
- Memory has no read/write ordering hazard: a read burst after a write burst sees the written data.
- Reset:
  - Forces IDLE, `busy`=0, `data_out`=0, `err`=0 and the beat counter to 0.
  - Memory contents are not cleared.
  - Reset mid-burst abandons the remaining beats. Write beats already executed stay stored.
- Not idle-gated: `data_out` holds its last value when no read beat executes.

## Timing
- Read latency: data for beat k is visible on `data_out` right after the posedge that executes beat k. Beat 0 executes on the accept edge, so data is sampleable at the next posedge.
- Read burst of N: data appears on N consecutive cycles with no bubbles.
- `busy` timing:
  - Rises after the accept edge when N>1.
  - Falls after the edge that executes the final beat.
  - Is high for exactly N-1 cycles; for N=1 it never rises.
- Back-to-back requests:
  - A new request may be presented on the first edge where `busy`=0 at the start of the cycle.
  - Single-word requests can be accepted on every edge.
- Write burst: the initiator presents beat k data on the cycle following beat k-1. The first word is sampled on the accept edge.
- `err` is asserted in the same cycle as the offending beat's `data_out` update or write.

## Test plan
- Single write/read: write 32'h27BDFFE8 to 0x80020000, then read with `access_size`=00 -> `data_out`=32'h27BDFFE8 one cycle after accept, `busy` stays 0.
- Byte order: write 32'h11223344 to 0x80020004, then read 0x80020004 -> 32'h11223344. Storage byte at offset 4 = 8'h11 (checked through a read of the same word after a 4-word write that overlaps it).
- 16-word burst: write burst of data 0..15 at 0x80020040 (`access_size`=11), then read burst -> `busy` high for 15 cycles, `data_out` = 0,1,…,15 on consecutive cycles. `enable` toggling during the burst has no effect.
- Out of range: read 0x8001FFFC -> `data_out`=0, `err` pulse. 4-word read at `base_addr`+`depth`-8 -> two valid words, then two beats of 0 each with `err`=1.
- Reset mid-burst: an 8-word write burst asserts `reset` after beat 3 -> `busy`=0 and `data_out`=0 immediately. Re-read shows words 0-3 written and words 4-7 unchanged.
- Back-to-back: single reads at 0x80020000 and 0x80020004 on consecutive edges -> both accepted, correct data on consecutive cycles.
